uart_rx_param: RTL
==================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter DIV, default 27, meaning clk cycles per 16x oversample tick (range 2..65535).
REQ-002 Parameter DATA_BITS, default 8, meaning data bits per frame (range 5..8).
REQ-003 Parameter PARITY_EN, default 0, meaning 1 = frame carries a parity bit after the data bits.
REQ-004 Parameter PARITY_ODD, default 0, meaning 1 = odd parity, 0 = even parity (ignored when PARITY_EN=0).
REQ-005 Parameter FIFO_DEPTH, default 8, meaning receive FIFO entries (power of two, 2..256).
REQ-006 Port clk, input, 1, meaning the single system clock; all logic is clocked on the rising edge.
REQ-007 Port rst, input, 1, meaning asynchronous, active-high reset.
REQ-008 Port tx_data, input, 1, meaning serial line from the remote transmitter; idles high and is asynchronous to clk.
REQ-009 Port forward_rx_data, input, 1, meaning pop request for the FIFO head.
REQ-010 Port rx_data, output, 8, meaning FIFO head byte; bits above DATA_BITS are zero.
REQ-011 Port rx_empty, output, 1, meaning FIFO holds no bytes.
REQ-012 Port rx_full, output, 1, meaning FIFO holds FIFO_DEPTH bytes.
REQ-013 Port rx_count, output, $clog2(FIFO_DEPTH+1), meaning number of bytes held in the FIFO.
REQ-014 Port frame_err, output, 1, meaning one-cycle pulse when the stop bit is sampled low.
REQ-015 Port parity_err, output, 1, meaning one-cycle pulse when the received parity bit mismatches.
REQ-016 Port overrun, output, 1, meaning one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-017 tx_data SHALL pass through a 2-flop synchroniser; all sampling uses the synchronised value.
REQ-018 A free-running divider SHALL emit a one-clk tick every DIV clks; the divider is restarted at the falling edge that begins a start bit.
REQ-019 The FSM SHALL have exactly the states IDLE, START, DATA, PARITY and STOP.
REQ-020 IDLE -> START on a synchronised high-to-low transition.
REQ-021 START: at tick 8, line low -> DATA; line high -> IDLE as a false start, with nothing written and no flags raised.
REQ-022 DATA: sample every 16 ticks after mid-start, LSB first; after DATA_BITS samples go to PARITY if PARITY_EN, else STOP.
REQ-023 PARITY: sample 16 ticks later; the expected value is the XOR of the data bits, inverted when PARITY_ODD.
REQ-024 STOP: sample 16 ticks later, then return to IDLE on the same cycle.
  - stop sampled low -> frame_err pulse, byte discarded.
  - parity mismatch -> parity_err pulse, byte discarded.
  - both faults -> both pulses on the same cycle, byte discarded.
REQ-025 A good byte SHALL be written to the FIFO on the cycle after the stop sample; rx_empty SHALL deassert on the following cycle.
REQ-026 The FIFO SHALL be first-word-fall-through: rx_data shows the head whenever rx_empty=0 and holds its previous value when empty.
REQ-027 A pop SHALL occur only on a cycle where forward_rx_data=1 and rx_empty=0; a pop while empty is ignored with no state change.
REQ-028 A write with rx_full=1 and no simultaneous pop SHALL drop the byte and pulse overrun; FIFO contents are unchanged.
REQ-029 A simultaneous write and pop when full SHALL accept both; the count stays at FIFO_DEPTH and overrun does not pulse.
REQ-030 A simultaneous write and pop when not full SHALL leave rx_count unchanged.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 rx_count SHALL update on the same edge as the write or pop that changes it.
REQ-033 A new start edge arriving during STOP processing SHALL be handled from IDLE on the next cycle; back-to-back frames are received with no lost frame.

Reset
REQ-034 rst=1 SHALL immediately force the following values: FSM=IDLE, divider=0, synchroniser flops=1, FIFO pointers=0, rx_count=0, rx_empty=1, rx_full=0, rx_data=0, frame_err=0, parity_err=0, overrun=0.
REQ-035 Reset asserted mid-frame SHALL abandon the frame; after release the block waits for a fresh falling edge.

Verification (DIV=4, so one bit = 64 clks; DATA_BITS=8, FIFO_DEPTH=4 unless noted)
REQ-036 Send 0xA5 8N1, then pulse forward_rx_data -> rx_data=0xA5, rx_count goes 1 then 0, rx_empty returns to 1, no error pulses.
REQ-037 Hold the line low for 20 clks only, then high -> no FIFO write, no error pulses, FSM returns to IDLE.
REQ-038 PARITY_EN=1, PARITY_ODD=0: send 0x03 with parity bit 1 -> parity_err pulses once and rx_empty stays 1; repeat with parity bit 0 -> 0x03 is stored.
REQ-039 Send 0x55 with the stop bit held low -> frame_err pulses once, no write; a following 0x66 is stored correctly.
REQ-040 Send 5 bytes 0x01..0x05 with no pops -> rx_full=1 after the 4th byte and overrun pulses on the 5th; pops return 0x01..0x04. Repeat with a pop on the 5th write cycle -> no overrun, and 0x05 is the last byte read out.
REQ-041 Assert rst mid-data-bit of 0xFF, release, then send 0x3C -> only 0x3C appears, rx_count=1.

Source files
------------

// File: rtl/uart_rx_param.sv
// 16x-oversampling UART receiver with a first-word-fall-through byte FIFO.
// A good byte is written one clk after the stop sample; a full FIFO drops it and pulses overrun unless popped that cycle.
module uart_rx_param #(
  parameter int DIV        = 27,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              tx_data,
  input  logic                              forward_rx_data,
  output logic [7:0]                        rx_data,
  output logic                              rx_empty,
  output logic                              rx_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   rx_count,
  output logic                              frame_err,
  output logic                              parity_err,
  output logic                              overrun
);

  localparam int              CW       = $clog2(FIFO_DEPTH + 1);
  localparam int              PW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0]     DIV_LAST = 16'(DIV - 1);
  localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [CW-1:0]   DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 r_state;
  logic                   r_sync1, r_sync2, r_sync_d;
  logic [15:0]            r_div;
  logic [3:0]             r_tick_cnt;
  logic [2:0]             r_bit_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par_bit;
  logic                   r_wr_req;
  logic [7:0]             r_wr_dat;
  logic                   r_frame_err, r_parity_err, r_overrun;
  logic [7:0]             r_mem [FIFO_DEPTH];
  logic [PW-1:0]          r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]          r_count;
  logic [7:0]             r_rx_data;

  logic                   w_fall, w_tick, w_par_bad;
  logic                   w_full, w_pop, w_push;
  logic [PW-1:0]          w_rd_ptr_nxt;
  logic [CW-1:0]          w_count_nxt;
  logic [7:0]             w_head_nxt;

  assign w_tick    = (r_div == DIV_LAST);
  assign w_fall    = r_sync_d & ~r_sync2;
  assign w_par_bad = (PARITY_EN != 0) && (r_par_bit != ((^r_shift) ^ (PARITY_ODD != 0)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_sync_d <= 1'b1;
    end else begin
      r_sync1  <= tx_data;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  // Restarting on the start edge keeps tick 8 near the middle of the start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_div <= 16'd0;
    else if (r_state == IDLE && w_fall) r_div <= 16'd0;
    else if (w_tick)                  r_div <= 16'd0;
    else                              r_div <= r_div + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_tick_cnt   <= 4'd0;
      r_bit_idx    <= 3'd0;
      r_shift      <= '0;
      r_par_bit    <= 1'b0;
      r_wr_req     <= 1'b0;
      r_wr_dat     <= 8'd0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_wr_req     <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state    <= START;
            r_tick_cnt <= 4'd0;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_tick_cnt == 4'd7) begin
              r_tick_cnt <= 4'd0;
              r_bit_idx  <= 3'd0;
              r_state    <= r_sync2 ? IDLE : DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if (r_tick_cnt == 4'd15) begin
              r_shift   <= {r_sync2, r_shift[DATA_BITS-1:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
              if (r_bit_idx == LAST_BIT) r_state <= (PARITY_EN != 0) ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if (r_tick_cnt == 4'd15) begin
              r_par_bit <= r_sync2;
              r_state   <= STOP;
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if (r_tick_cnt == 4'd15) begin
              r_state      <= IDLE;
              r_frame_err  <= ~r_sync2;
              r_parity_err <= w_par_bad;
              r_wr_req     <= r_sync2 & ~w_par_bad;
              r_wr_dat     <= 8'(r_shift);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_full       = (r_count == DEPTH_C);
  assign w_pop        = forward_rx_data && (r_count != '0);
  assign w_push       = r_wr_req && (!w_full || w_pop);
  assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + PW'(1)) : r_rd_ptr;
  // The incoming byte becomes the head when it lands in the slot the read pointer moves to.
  assign w_head_nxt   = (w_push && (w_rd_ptr_nxt == r_wr_ptr)) ? r_wr_dat : r_mem[w_rd_ptr_nxt];

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (w_pop && !w_push) w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_wr_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_rx_data <= 8'd0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_count   <= w_count_nxt;
      if (w_count_nxt != '0) r_rx_data <= w_head_nxt;
      r_overrun <= r_wr_req && w_full && !w_pop;
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_empty   = (r_count == '0);
  assign rx_full    = w_full;
  assign rx_count   = r_count;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;

endmodule
